// File: rtl/qenc_velocity.sv
// Quadrature-encoder velocity estimator.
// Samples a free-running position count once per programmable window and
// reports the signed modular delta, its sign, and a standstill flag derived
// from a run of consecutive zero-delta windows.
module qenc_velocity #(
    parameter int NB       = 32,
    parameter int PB       = 24,
    parameter int STOP_WIN = 4
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          i_enable,
    input  logic [NB-1:0] i_position,
    input  logic [PB-1:0] i_period,
    output logic [NB-1:0] o_velocity,
    output logic          o_valid,
    output logic          o_dir,
    output logic          o_stopped
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ARM  = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;

    // Zero-window counter only needs to reach STOP_WIN, then it saturates.
    localparam int            ZW   = (STOP_WIN < 1) ? 1 : $clog2(STOP_WIN + 1);
    localparam logic [ZW-1:0] ZSAT = ZW'(STOP_WIN);

    logic [1:0]    r_state;
    logic [PB-1:0] r_cnt;
    logic [PB-1:0] r_win;
    logic [NB-1:0] r_base;
    logic [ZW-1:0] r_zcnt;

    logic [PB-1:0] w_period_eff;
    logic [NB-1:0] w_delta;
    logic          w_win_end;
    logic [ZW-1:0] w_zcnt_nxt;

    // Window length, modular delta, window-end detect and next zero-run count.
    always_comb begin
        w_period_eff = (i_period == '0) ? PB'(1) : i_period;
        // Modular subtraction handles encoder wrap in either direction.
        w_delta      = i_position - r_base;
        w_win_end    = (r_state == RUN) && (r_cnt == (r_win - PB'(1)));
        w_zcnt_nxt   = '0;
        if (w_delta == '0) begin
            w_zcnt_nxt = (r_zcnt == ZSAT) ? r_zcnt : (r_zcnt + ZW'(1));
        end
    end

    // Measurement FSM plus output registers; disable always beats a window end.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_win      <= '0;
            r_base     <= '0;
            r_zcnt     <= '0;
            o_velocity <= '0;
            o_valid    <= 1'b0;
            o_dir      <= 1'b0;
            o_stopped  <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_enable) r_state <= ARM;
                end
                ARM, RUN: begin
                    if (!i_enable) begin
                        // Partial window is dropped; outputs return to a clean state.
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_zcnt     <= '0;
                        o_velocity <= '0;
                        o_dir      <= 1'b0;
                        o_stopped  <= 1'b0;
                    end else if (r_state == ARM) begin
                        r_base  <= i_position;
                        r_win   <= w_period_eff;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else if (w_win_end) begin
                        o_velocity <= w_delta;
                        o_dir      <= w_delta[NB-1];
                        o_valid    <= 1'b1;
                        r_zcnt     <= w_zcnt_nxt;
                        o_stopped  <= (w_zcnt_nxt >= ZSAT);
                        r_base     <= i_position;
                        r_cnt      <= '0;
                        // New period only applies from the following window.
                        r_win      <= w_period_eff;
                    end else begin
                        r_cnt <= r_cnt + PB'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qenc_velocity.sv
// Directed bench for qenc_velocity: hand-computed window deltas, latencies,
// standstill detection, disable/reset behaviour and period changes.
module tb_qenc_velocity;

    logic        clk;
    logic        clk_en;
    logic        i_reset;
    logic        i_enable;
    logic [31:0] i_position;
    logic [23:0] i_period;
    logic [31:0] o_velocity;
    logic        o_valid;
    logic        o_dir;
    logic        o_stopped;

    int n_chk = 0;
    int n_err = 0;
    int step  = 0;
    int n;
    int nv;

    qenc_velocity #(.NB(32), .PB(24), .STOP_WIN(4)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .i_position (i_position),
        .i_period   (i_period),
        .o_velocity (o_velocity),
        .o_valid    (o_valid),
        .o_dir      (o_dir),
        .o_stopped  (o_stopped)
    );

    // Gateable clock so reset can be applied with clk frozen.
    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: outputs settle 1 time unit after the edge, then position advances.
    task automatic tick();
        @(posedge clk);
        #1;
        i_position = i_position + 32'(step);
    endtask

    task automatic wait_valid(input int budget, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!o_valid && cnt < budget);
        check("valid_seen", {63'd0, o_valid}, 64'd1);
    endtask

    task automatic disable_blk();
        i_enable = 1'b0;
        tick();
    endtask

    initial begin
        clk_en     = 1'b1;
        i_reset    = 1'b0;
        i_enable   = 1'b0;
        i_position = '0;
        i_period   = '0;

        #12;
        check("rst_vel",   o_velocity, 0);
        check("rst_valid", o_valid, 0);
        check("rst_dir",   o_dir, 0);
        check("rst_stop",  o_stopped, 0);
        check("rst_state", dut.r_state, 0);
        @(negedge clk);
        i_reset = 1'b1;
        repeat (3) tick();
        check("idle_hold", dut.r_state, 0);

        // Forward: +3/cycle, period 10
        i_period = 24'd10; i_position = 32'd1000; step = 3; i_enable = 1'b1;
        tick();
        check("fwd_arm", dut.r_state, 1);
        wait_valid(40, n);
        check("fwd_lat",  n, 11);
        check("fwd_vel",  o_velocity, 30);
        check("fwd_dir",  o_dir, 0);
        tick();
        check("fwd_pulse", o_valid, 0);
        wait_valid(40, n);
        check("fwd_per",  n, 9);
        check("fwd_vel2", o_velocity, 30);

        // Asynchronous reset with clock frozen (just after a window end)
        clk_en = 1'b0;
        #3;
        i_reset = 1'b0;
        #1;
        check("arst_vel",   o_velocity, 0);
        check("arst_valid", o_valid, 0);
        check("arst_dir",   o_dir, 0);
        check("arst_stop",  o_stopped, 0);
        check("arst_state", dut.r_state, 0);
        i_enable = 1'b0;
        #1; i_reset = 1'b1;
        #1; clk_en = 1'b1;
        repeat (2) tick();
        check("arst_idle", dut.r_state, 0);

        // Reverse through zero: -2/cycle, period 8
        i_period = 24'd8; i_position = 32'd6; step = -2; i_enable = 1'b1;
        tick();
        wait_valid(40, n);
        check("rev_lat",  n, 9);
        check("rev_vel",  o_velocity, 32'hFFFF_FFF0);
        check("rev_dir",  o_dir, 1);
        wait_valid(40, n);
        check("rev_per",  n, 8);
        check("rev_vel2", o_velocity, 32'hFFFF_FFF0);
        disable_blk();
        check("dis_vel", o_velocity, 0);
        check("dis_dir", o_dir, 0);

        // Wrap forward: FFFF_FFFE -> 3
        step = 0; i_period = 24'd4; i_position = 32'hFFFF_FFFE; i_enable = 1'b1;
        tick();
        tick();
        i_position = 32'd3;
        wait_valid(20, n);
        check("wrap_lat", n, 4);
        check("wrap_vel", o_velocity, 5);
        check("wrap_dir", o_dir, 0);
        disable_blk();

        // Standstill at 100, period 5
        i_position = 32'd100; step = 0; i_period = 24'd5; i_enable = 1'b1;
        tick();
        for (int w = 1; w <= 5; w++) begin
            wait_valid(20, n);
            check("stand_vel",  o_velocity, 0);
            check("stand_stop", o_stopped, (w >= 4) ? 1 : 0);
        end
        i_position = 32'd101;
        wait_valid(20, n);
        check("move_vel",  o_velocity, 1);
        check("move_stop", o_stopped, 0);
        disable_blk();

        // Period 0 behaves as period 1
        i_period = 24'd0; i_position = 32'd0; step = 7; i_enable = 1'b1;
        tick();
        wait_valid(10, n);
        check("p0_lat", n, 2);
        check("p0_vel", o_velocity, 7);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("p0_cont", o_valid, 1);
            check("p0_velk", o_velocity, 7);
        end
        disable_blk();

        // Disable on the same edge as a window end
        i_period = 24'd4; step = 1; i_enable = 1'b1;
        tick();
        wait_valid(20, n);
        check("se_lat", n, 5);
        repeat (3) tick();
        i_enable = 1'b0;
        tick();
        check("se_valid", o_valid, 0);
        check("se_state", dut.r_state, 0);

        // Disable mid-window at count 12
        i_period = 24'd20; i_position = 32'd0; step = 5; i_enable = 1'b1;
        tick();
        wait_valid(40, n);
        check("mw_lat", n, 21);
        check("mw_vel", o_velocity, 100);
        nv = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            nv += int'(o_valid);
        end
        check("mw_novalid", nv, 0);
        disable_blk();
        check("mw_valid", o_valid, 0);
        check("mw_vel0",  o_velocity, 0);
        check("mw_state", dut.r_state, 0);

        // Re-enable re-captures baseline; 20 -> 6 change mid-window
        i_position = 32'd5000; step = 5; i_enable = 1'b1;
        tick();
        repeat (6) tick();
        i_period = 24'd6;
        wait_valid(40, n);
        check("pc_lat",  n, 15);
        check("pc_vel",  o_velocity, 100);
        wait_valid(40, n);
        check("pc_next", n, 6);
        check("pc_vel2", o_velocity, 30);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
